adc_deserializer: RTL and testbench
===================================

Name: adc_deserializer

Overview:
- Front end of the audio path: receives the I2S serial stream from the codec ADC and produces parallel 18-bit signed samples plus the 48 kHz sample-enable pulse.
- Outputs feed the channel block's data_in and data_en directly; one instance serves both channels (left_out, right_out).
- All logic runs in the master clock domain. bclk/lrck/sdata are treated as asynchronous inputs, synchronised, and sampled on detected edges.

Parameters:
- NBITS, 18, sample width delivered on left_out/right_out (1..32).
- SLOT_MAX, 32, maximum bclk periods per half-frame; counter width = clog2(SLOT_MAX)+1.
- I2S_DELAY, 1, bclk rising edges between an lrck transition and the MSB (1 = I2S, 0 = left-justified).

Ports:
- clock  input  1  master clock; must be ≥ 4× bclk frequency
- reset  input  1  asynchronous, active-high; clears all state
- bclk_in  input  1  serial bit clock from codec (asynchronous)
- lrck_in  input  1  word select: 0 = left slot, 1 = right slot (asynchronous)
- sdata_in  input  1  serial data, MSB first, two's complement (asynchronous)
- left_out  output  NBITS  signed left sample, registered
- right_out  output  NBITS  signed right sample, registered
- data_en  output  1  one-clock pulse when left_out/right_out update (48 kHz)

Behaviour:
- Reset (asynchronous, active-high):
  - left_out = 0, right_out = 0, data_en = 0.
  - Shift register, bit counter and pending-left register cleared; FSM enters SYNC.
- Synchronisers: 2-FF synchroniser on each of bclk_in, lrck_in, sdata_in. A third stage on bclk gives edge detection.
  - bclk_rise = one-clock pulse when the synchronised bclk goes 0→1.
  - All sampling happens only in bclk_rise cycles. lrck and sdata are taken from the same synchroniser depth as bclk, so their relative alignment is preserved.
- Slot boundary: a bclk_rise in which the synchronised lrck differs from the lrck value latched at the previous bclk_rise. That bclk_rise is slot position 0.
- Bit position: sdata at slot position p is bit (NBITS-1) - (p - I2S_DELAY), for I2S_DELAY ≤ p < I2S_DELAY+NBITS. Positions outside this window are ignored (extra LSBs discarded).
- FSM:
  - SYNC: ignore data until the first slot boundary, then go to SHIFT. The first half-frame after reset is discarded.
  - SHIFT: shift sdata into the shift register at valid positions. After NBITS bits go to HOLD.
  - HOLD: ignore bits until the next slot boundary, then go to SHIFT.
- Short slot: a slot boundary arriving before NBITS bits are captured closes the word. Captured bits stay MSB-aligned; the remaining LSBs are 0. The FSM goes to SHIFT for the new slot.
- Word close, left slot (lrck = 0): word stored in the pending-left register; no output change.
- Word close, right slot:
  - On the next clock, left_out ← pending-left and right_out ← the right word, simultaneously.
  - data_en is high for exactly that one clock.
  - Latency: the last right bit's bclk_rise cycle + 1 clock.
- A right word completing without a left word captured since SYNC exit produces no data_en.
- Slot counter saturates at SLOT_MAX. A stuck lrck (counter saturated) returns the FSM to SYNC; outputs hold their last values.
- A slot boundary and a word-close on the same bclk_rise: close first, then the new slot starts at position 0.
- Reset mid-frame: outputs zero immediately; a partial word is never emitted.

Optional Feature:
- Macro: ADC_DESERIALIZER_FRAME_ERR_EN.
- Defined:
  - Adds output port frame_err (1 bit, registered, reset 0).
  - frame_err is sticky: set on any short slot or SLOT_MAX saturation after the first SYNC exit; cleared only by reset.
- Undefined: port and detection logic absent; behaviour otherwise identical.

Test Plan:
- Reset: assert reset asynchronously mid-frame (between clock edges) -> left_out = 0, right_out = 0, data_en = 0 immediately; first post-reset half-frame is discarded; first data_en follows the next complete left+right pair.
- Nominal I2S (NBITS = 18, 64 bclk/frame, clock = 8× bclk): left = 18'h1FFFF, right = 18'h20001 -> one data_en pulse per frame; left_out = 131071, right_out = -131071; data_en one clock after the last right bclk_rise.
- Left-justified (I2S_DELAY = 0): left = 18'h2AAAA, right = 18'h15555 -> outputs match exactly.
- Short slot (12 bclk per slot): MSB-first pattern 12'hFFF -> outputs = 18'h3FFC0; frame_err = 1 when ADC_DESERIALIZER_FRAME_ERR_EN is defined.
- Stuck lrck (held 0 for 40 bclk): no data_en; FSM returns to SYNC; after a normal frame resumes, the correct pair is output after one discarded half-frame.
- 100 random frames compared against a reference model -> data_en count = frames - 1; every left/right value matches.

Source files
------------

// File: rtl/adc_deserializer.sv
// I2S / left-justified serial-to-parallel front end for the codec ADC.
// Optional sticky frame_err port: define ADC_DESERIALIZER_FRAME_ERR_EN.
module adc_deserializer #(
    parameter int NBITS     = 18,
    parameter int SLOT_MAX  = 32,
    parameter int I2S_DELAY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    bclk_in,
    input  logic                    lrck_in,
    input  logic                    sdata_in,
    output logic signed [NBITS-1:0] left_out,
    output logic signed [NBITS-1:0] right_out,
    output logic                    data_en
`ifdef ADC_DESERIALIZER_FRAME_ERR_EN
    ,
    output logic                    frame_err
`endif
);

    localparam int CW = $clog2(SLOT_MAX) + 1;
    localparam int NW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] POS_SAT = CW'(SLOT_MAX);
    localparam logic [NW-1:0] NBITS_C = NW'(NBITS);

    typedef enum logic [1:0] {SYNC, SHIFT, HOLD} state_t;

    state_t           r_state;
    logic [2:0]       r_bclk_s;
    logic [1:0]       r_lrck_s;
    logic [1:0]       r_sdata_s;
    logic             r_lrck_prev;
    logic [CW-1:0]    r_pos;
    logic [NBITS-1:0] r_shift;
    logic [NW-1:0]    r_nbit;
    logic [NBITS-1:0] r_pend;
    logic             r_have_left;

    logic             w_bclk_rise;
    logic             w_lrck;
    logic             w_sdata;
    logic             w_boundary;
    logic [CW-1:0]    w_pos;
    logic             w_sat;
    logic             w_short;
    logic             w_active;
    logic             w_in_window;
    logic             w_cap;
    logic [NBITS-1:0] w_base_shift;
    logic [NW-1:0]    w_base_nbit;
    logic [NBITS-1:0] w_shift_next;
    logic [NW-1:0]    w_nbit_next;
    logic             w_full;
    logic             w_close;
    logic [NBITS-1:0] w_word;
    logic             w_word_right;

    always_comb begin
        w_bclk_rise  = r_bclk_s[1] & ~r_bclk_s[2];
        w_lrck       = r_lrck_s[1];
        w_sdata      = r_sdata_s[1];
        w_boundary   = w_bclk_rise & (w_lrck != r_lrck_prev);
        w_pos        = w_boundary ? '0 : ((r_pos == POS_SAT) ? POS_SAT : r_pos + 1'b1);
        w_sat        = w_bclk_rise & ~w_boundary & (w_pos == POS_SAT);
        // A boundary while still shifting is a short slot: the old word closes
        // in the same bclk_rise that opens the new slot at position 0.
        w_short      = w_boundary & (r_state == SHIFT);
        w_active     = w_bclk_rise & ~w_sat & (w_boundary | (r_state == SHIFT));
        w_in_window  = ({1'b0, w_pos} + 1'b1) > (CW + 1)'(I2S_DELAY);
        w_cap        = w_active & w_in_window;
        w_base_shift = w_boundary ? '0 : r_shift;
        w_base_nbit  = w_boundary ? '0 : r_nbit;
        w_shift_next = (w_base_shift << 1) | NBITS'(w_sdata);
        w_nbit_next  = w_base_nbit + 1'b1;
        w_full       = w_cap & (w_nbit_next == NBITS_C);
        w_close      = w_short | w_full;
        w_word       = w_short ? (r_shift << (NBITS_C - r_nbit)) : w_shift_next;
        w_word_right = w_short ? r_lrck_prev : w_lrck;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= SYNC;
            r_bclk_s    <= '0;
            r_lrck_s    <= '0;
            r_sdata_s   <= '0;
            r_lrck_prev <= 1'b0;
            r_pos       <= '0;
            r_shift     <= '0;
            r_nbit      <= '0;
            r_pend      <= '0;
            r_have_left <= 1'b0;
            left_out    <= '0;
            right_out   <= '0;
            data_en     <= 1'b0;
        end else begin
            r_bclk_s  <= {r_bclk_s[1:0], bclk_in};
            r_lrck_s  <= {r_lrck_s[0], lrck_in};
            r_sdata_s <= {r_sdata_s[0], sdata_in};
            data_en   <= 1'b0;
            if (w_bclk_rise) begin
                r_lrck_prev <= w_lrck;
                r_pos       <= w_pos;
                if (w_cap) begin
                    r_shift <= w_shift_next;
                    r_nbit  <= w_nbit_next;
                end else if (w_boundary) begin
                    r_shift <= '0;
                    r_nbit  <= '0;
                end
                if (w_close) begin
                    if (!w_word_right) begin
                        r_pend      <= w_word;
                        r_have_left <= 1'b1;
                    end else if (r_have_left) begin
                        left_out  <= r_pend;
                        right_out <= w_word;
                        data_en   <= 1'b1;
                    end
                end
                if (w_sat) begin
                    r_state     <= SYNC;
                    r_have_left <= 1'b0;
                end else if (w_full) begin
                    r_state <= HOLD;
                end else if (w_boundary) begin
                    r_state <= SHIFT;
                end
            end
        end
    end

`ifdef ADC_DESERIALIZER_FRAME_ERR_EN
    logic r_frame_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
        end else if (w_short | (w_sat & (r_state != SYNC))) begin
            r_frame_err <= 1'b1;
        end
    end

    assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_adc_deserializer.sv
// Bench for adc_deserializer: an I2S instance and a left-justified instance share
// bclk/lrck; a slot-level model predicts each output pair.
module tb_adc_deserializer;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        bclk  = 1'b0;
    logic        lrck  = 1'b0;
    logic        sd_a  = 1'b0;
    logic        sd_b  = 1'b0;
    logic [17:0] la, ra, lb, rb;
    logic        ena, enb;
`ifdef ADC_DESERIALIZER_FRAME_ERR_EN
    logic        fea, feb;
`endif

    always #5 clk = ~clk;

    adc_deserializer #(.NBITS(18), .SLOT_MAX(32), .I2S_DELAY(1)) u_i2s (
        .clock(clk), .reset(rst), .bclk_in(bclk), .lrck_in(lrck), .sdata_in(sd_a),
        .left_out(la), .right_out(ra), .data_en(ena)
`ifdef ADC_DESERIALIZER_FRAME_ERR_EN
        , .frame_err(fea)
`endif
    );

    adc_deserializer #(.NBITS(18), .SLOT_MAX(32), .I2S_DELAY(0)) u_lj (
        .clock(clk), .reset(rst), .bclk_in(bclk), .lrck_in(lrck), .sdata_in(sd_b),
        .left_out(lb), .right_out(rb), .data_en(enb)
`ifdef ADC_DESERIALIZER_FRAME_ERR_EN
        , .frame_err(feb)
`endif
    );

    int passes = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // Slot-level reference state, one entry per instance.
    logic [35:0] q_a[$];
    logic [35:0] q_b[$];
    bit          m_have[2];
    bit          m_last[2];
    logic [17:0] m_pend[2];
    logic [35:0] hold[2];
    int          cnt[2];
    bit          arm_lat = 1'b0;
    bit          lat_pending = 1'b0;
    int          t_last = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [17:0] captured(input logic [17:0] w, input int len, input int dly);
        int n;
        logic [17:0] mask;
        n = len - dly;
        if (n < 0) n = 0;
        if (n > 18) n = 18;
        mask = '1;
        mask = mask << (18 - n);
        return w & mask;
    endfunction

    task automatic model_slot(input int i, input bit lr, input int len, input logic [17:0] w);
        logic [17:0] cw;
        if (lr != m_last[i]) begin
            cw = captured(w, len, (i == 0) ? 1 : 0);
            if (!lr) begin
                m_pend[i] = cw;
                m_have[i] = 1'b1;
            end else if (m_have[i]) begin
                if (i == 0) q_a.push_back({m_pend[i], cw});
                else        q_b.push_back({m_pend[i], cw});
            end
            if (len > 32) m_have[i] = 1'b0;
        end
        m_last[i] = lr;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_have[i] = 1'b0;
            m_last[i] = 1'b0;
        end
        q_a.delete();
        q_b.delete();
    endtask

    task automatic cmp_one(input int i, input logic en, input logic [17:0] l, input logic [17:0] r);
        logic [35:0] e;
        bit          avail;
        string       nm;
        nm = (i == 0) ? "i2s" : "lj";
        if (en) begin
            cnt[i]++;
            avail = (i == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
            if (!avail) begin
                checks++;
                $display("FAIL %s_unexpected_en: got data_en=1 expected no pulse", nm);
            end else begin
                e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
                check({nm, "_left"}, l, e[35:18]);
                check({nm, "_right"}, r, e[17:0]);
                hold[i] = e;
            end
            if (i == 0 && lat_pending) begin
                check("i2s_latency", cyc - t_last, 3);
                lat_pending = 1'b0;
            end
        end else begin
            check({nm, "_hold"}, {l, r}, hold[i]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) begin
            hold[0] = '0;
            hold[1] = '0;
        end else begin
            cmp_one(0, ena, la, ra);
            cmp_one(1, enb, lb, rb);
        end
    endtask

    task automatic send_slot(input bit lr, input int len, input logic [17:0] w, input int rst_pos);
        model_slot(0, lr, len, w);
        model_slot(1, lr, len, w);
        for (int p = 0; p < len; p++) begin
            tick();
            bclk = 1'b0;
            lrck = lr;
            sd_a = (p >= 1 && p <= 18) ? w[18-p] : 1'($urandom_range(1, 0));
            sd_b = (p < 18) ? w[17-p] : 1'($urandom_range(1, 0));
            repeat (3) tick();
            tick();
            bclk = 1'b1;
            if (arm_lat && lr && p == 18) begin
                t_last      = cyc;
                lat_pending = 1'b1;
            end
            if (p == rst_pos) begin
                #3 rst = 1'b1;
                #1;
                check("midrst_left_a", la, 0);
                check("midrst_right_a", ra, 0);
                check("midrst_en_a", ena, 0);
                check("midrst_left_b", lb, 0);
                check("midrst_right_b", rb, 0);
`ifdef ADC_DESERIALIZER_FRAME_ERR_EN
                check("midrst_frame_err", {fea, feb}, 2'b00);
`endif
            end
            repeat (3) tick();
        end
    endtask

    task automatic send_frame(input logic [17:0] l, input logic [17:0] r);
        send_slot(1'b0, 32, l, -1);
        send_slot(1'b1, 32, r, -1);
    endtask

    initial begin
        int c0, c1;
        model_reset();
        repeat (3) tick();
        check("rst_left_a", la, 0);
        check("rst_right_a", ra, 0);
        check("rst_en_a", ena, 0);
        check("rst_left_b", lb, 0);
        check("rst_right_b", rb, 0);
        check("rst_en_b", enb, 0);
`ifdef ADC_DESERIALIZER_FRAME_ERR_EN
        check("rst_frame_err", {fea, feb}, 2'b00);
`endif
        tick();
        rst = 1'b0;
        repeat (4) tick();

        // Nominal I2S frames, latency pinned on the I2S instance.
        arm_lat = 1'b1;
        repeat (3) send_frame(18'h1FFFF, 18'h20001);
        arm_lat = 1'b0;
        check("nom_left_a", 64'($signed(la)), 64'(131071));
        check("nom_right_a", 64'($signed(ra)), 64'(-131071));
        check("nom_right_b", rb, 18'h20001);

        repeat (2) send_frame(18'h2AAAA, 18'h15555);
        check("lj_left_b", lb, 18'h2AAAA);
        check("lj_right_b", rb, 18'h15555);
        check("lj_left_a", la, 18'h2AAAA);

        // 12-bclk slots: LJ keeps 12 MSBs, I2S loses one to the delay slot.
        repeat (2) begin
            send_slot(1'b0, 12, 18'h3FFFF, -1);
            send_slot(1'b1, 12, 18'h3FFFF, -1);
        end
        check("short_left_b", lb, 18'h3FFC0);
        check("short_right_b", rb, 18'h3FFC0);
        check("short_left_a", la, 18'h3FF80);
        check("short_right_a", ra, 18'h3FF80);
`ifdef ADC_DESERIALIZER_FRAME_ERR_EN
        check("short_frame_err", {fea, feb}, 2'b11);
`endif
        send_frame(18'h12345, 18'h2BCDE);

        // Stuck lrck: no pulse through the stall and the first resumed frame.
        c0 = cnt[0];
        c1 = cnt[1];
        send_slot(1'b0, 40, 18'h0F0F0, -1);
        send_frame(18'h11111, 18'h22222);
        check("stuck_no_en_a", cnt[0] - c0, 0);
        check("stuck_no_en_b", cnt[1] - c1, 0);
        send_frame(18'h0ABCD, 18'h3DCBA);
        check("resume_left_a", la, 18'h0ABCD);
        check("resume_right_a", ra, 18'h3DCBA);
        check("resume_left_b", lb, 18'h0ABCD);
        check("resume_right_b", rb, 18'h3DCBA);

        // Reset asserted between clock edges partway through a left slot.
        send_slot(1'b0, 32, 18'h15A5A, 10);
        tick();
        rst = 1'b0;
        model_reset();
        send_slot(1'b1, 32, 18'h01234, -1);
        send_frame(18'h3ABCD, 18'h05432);
        check("postrst_left_a", la, 18'h3ABCD);
        check("postrst_right_b", rb, 18'h05432);

        // Clean reset with the serial lines idle, then random frames.
        tick();
        bclk = 1'b0;
        lrck = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        c0 = cnt[0];
        c1 = cnt[1];
        for (int f = 0; f < 100; f++) send_frame(18'($urandom), 18'($urandom));
        repeat (10) tick();
        check("rand_count_a", cnt[0] - c0, 99);
        check("rand_count_b", cnt[1] - c1, 99);
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
